// File: rtl/imm_extender_pipe.sv
// imm_extender_pipe
//   Decode-stage immediate generator registered at the ID/EX boundary.
//   Picks one of the standard immediate fields out of the instruction word and
//   zero/sign-extends it to DATA_W. A prefix instruction (opcode PREFIX_OP in
//   the top five bits) latches PREFIX_W high-order bits. Those bits are glued
//   onto the next non-prefix instruction's raw field to form a wide immediate.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active high (highest priority)
//   in_valid   in   inst/mode are valid this cycle
//   stall      in   hold every register
//   flush      in   drop pending prefix and output (beats stall)
//   inst       in   [INST_W-1:0] instruction word
//   mode       in   [2:0] field select: 0=Z[7:0] 1=S[10:0] 2=S[7:0] 3=S[4:0] 4=S[3:0]
//   out_valid  out  imm is valid
//   imm        out  [DATA_W-1:0] extended immediate
//   prefixed   out  imm was built from a latched prefix
//   prefix_err out  one-cycle pulse: a prefix replaced an unconsumed prefix
module imm_extender_pipe #(
    parameter int         INST_W    = 16,
    parameter int         DATA_W    = 16,
    parameter int         PREFIX_W  = 11,
    parameter logic [4:0] PREFIX_OP = 5'b11110
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [INST_W-1:0] inst,
    input  logic [2:0]        mode,
    output logic              out_valid,
    output logic [DATA_W-1:0] imm,
    output logic              prefixed,
    output logic              prefix_err
);

    // Wide enough for the largest prefix+field concatenation and for DATA_W.
    localparam int EXT_W = (DATA_W > PREFIX_W + 11) ? DATA_W : PREFIX_W + 11;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HELD = 1'b1;

    logic [0:0]          state;
    logic [PREFIX_W-1:0] pfx_reg;
    logic                is_pfx;
    logic                mode_ok;
    logic [EXT_W-1:0]    pfx_ext;
    logic [DATA_W-1:0]   imm_idle;
    logic [DATA_W-1:0]   imm_held;

    assign is_pfx  = (inst[INST_W-1 -: 5] == PREFIX_OP);
    assign mode_ok = (mode <= 3'd4);

    // The prefix is sign-extended up front. Shifting it left by k and OR-ing
    // in the raw field gives {pfx, field} sign-extended from the prefix MSB.
    // When PREFIX_W+k >= DATA_W the extension bits fall above DATA_W and the
    // truncation below discards them, so one expression covers both cases.
    assign pfx_ext = {{(EXT_W-PREFIX_W){pfx_reg[PREFIX_W-1]}}, pfx_reg};

    always_comb begin
        imm_idle = '0;
        imm_held = '0;
        case (mode)
            3'd0: begin
                imm_idle = DATA_W'(EXT_W'(inst[7:0]));
                imm_held = DATA_W'((pfx_ext << 8) | EXT_W'(inst[7:0]));
            end
            3'd1: begin
                imm_idle = DATA_W'({{(EXT_W-11){inst[10]}}, inst[10:0]});
                imm_held = DATA_W'((pfx_ext << 11) | EXT_W'(inst[10:0]));
            end
            3'd2: begin
                imm_idle = DATA_W'({{(EXT_W-8){inst[7]}}, inst[7:0]});
                imm_held = DATA_W'((pfx_ext << 8) | EXT_W'(inst[7:0]));
            end
            3'd3: begin
                imm_idle = DATA_W'({{(EXT_W-5){inst[4]}}, inst[4:0]});
                imm_held = DATA_W'((pfx_ext << 5) | EXT_W'(inst[4:0]));
            end
            3'd4: begin
                imm_idle = DATA_W'({{(EXT_W-4){inst[3]}}, inst[3:0]});
                imm_held = DATA_W'((pfx_ext << 4) | EXT_W'(inst[3:0]));
            end
            default: begin
                imm_idle = '0;
                imm_held = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            imm        <= '0;
            prefixed   <= 1'b0;
            prefix_err <= 1'b0;
            pfx_reg    <= '0;
            state      <= S_IDLE;
        end else if (flush) begin
            // imm is left alone; only the qualifiers drop.
            out_valid  <= 1'b0;
            prefixed   <= 1'b0;
            prefix_err <= 1'b0;
            state      <= S_IDLE;
        end else if (stall) begin
            // hold everything
        end else if (in_valid) begin
            if (is_pfx) begin
                pfx_reg    <= inst[PREFIX_W-1:0];
                prefix_err <= (state == S_HELD);
                state      <= S_HELD;
                out_valid  <= 1'b0;
                prefixed   <= 1'b0;
            end else begin
                out_valid  <= 1'b1;
                prefix_err <= 1'b0;
                state      <= S_IDLE;
                if (!mode_ok) begin
                    imm      <= '0;
                    prefixed <= 1'b0;
                end else if (state == S_HELD) begin
                    imm      <= imm_held;
                    prefixed <= 1'b1;
                end else begin
                    imm      <= imm_idle;
                    prefixed <= 1'b0;
                end
            end
        end else begin
            // Bubble: the prefix (state/pfx_reg) survives.
            out_valid  <= 1'b0;
            prefixed   <= 1'b0;
            prefix_err <= 1'b0;
        end
    end

endmodule

// File: doc/imm_extender_pipe.md
Name: imm_extender_pipe

Overview:
- Registered, parametrised immediate-generation stage in the decode path of the 16-bit CPU.
- Selects one of the standard immediate fields from the instruction word and zero- or sign-extends it to the datapath width. Results register at the ID/EX boundary.
- Adds prefix support: an immediate prefix instruction supplies high-order bits that are concatenated with the next instruction's field. This gives wide immediates without extra decode logic.
- Honours pipeline stall and flush.

Parameters:
- INST_W, 16, instruction word width.
- DATA_W, 16, output immediate width.
- PREFIX_W, 11, number of prefix bits latched, taken from inst[PREFIX_W-1:0].
- PREFIX_OP, 5'b11110, opcode in inst[INST_W-1:INST_W-5] identifying a prefix instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  inst/mode valid this cycle.
- stall  in  1  hold all state and outputs.
- flush  in  1  discard pending prefix and output.
- inst  in  INST_W  instruction word.
- mode  in  3  field select: 0=Z[7:0], 1=S[10:0], 2=S[7:0], 3=S[4:0], 4=S[3:0], 5..7=reserved.
- out_valid  out  1  imm valid.
- imm  out  DATA_W  extended immediate.
- prefixed  out  1  imm was built with a prefix.
- prefix_err  out  1  one-cycle pulse: a prefix overwrote an unconsumed prefix.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, imm=0, prefixed=0, prefix_err=0, pfx_reg=0, state=IDLE. Reset has priority over everything.
- State machine: IDLE, HELD (prefix latched and not yet consumed).
- Priority at each edge: rst > flush > stall > normal.
- Flush: out_valid=0, prefixed=0, prefix_err=0, state=IDLE. imm holds its value. Flush wins even when stall=1.
- Stall (no flush): every register holds, including out_valid and the prefix_err level.
- Accept condition: in_valid & !stall & !flush. Define is_pfx as inst[INST_W-1:INST_W-5]==PREFIX_OP.
- Accept with is_pfx:
  - pfx_reg<=inst[PREFIX_W-1:0]; state<=HELD; out_valid<=0.
  - prefix_err<=1 if the state was already HELD, else 0.
- Accept without is_pfx: out_valid<=1 and prefix_err<=0. Field width k is 8, 11, 8, 5, 4 for modes 0..4.
  - Mode 5..7: imm<=0, prefixed<=0, state<=IDLE.
  - State IDLE: imm<=field extended to DATA_W. Mode 0 zero-extends; modes 1..4 sign-extend from bit k-1. prefixed<=0.
  - State HELD: form C={pfx_reg, inst[k-1:0]} (PREFIX_W+k bits, raw field bits).
    - If PREFIX_W+k>=DATA_W: imm<=C[DATA_W-1:0] (truncate).
    - Otherwise: imm<=C sign-extended from its MSB, i.e. pfx_reg[PREFIX_W-1].
    - prefixed<=1; state<=IDLE.
- No accept (in_valid=0, no stall, no flush): out_valid<=0, prefixed<=0, prefix_err<=0. imm holds. State holds, so a prefix persists across bubbles.
- Latency: exactly 1 cycle from accept to out_valid/imm.
- Prefix followed by flush: the prefix is lost, and the next instruction extends as in IDLE.
- Width rules: all extensions are computed at max(DATA_W, PREFIX_W+11) bits internally, then truncated. No reliance on unsized literals; replication counts are derived from parameters.
- Target size: 120–250 lines RTL.

Test Plan:
1. Reset then plain modes (defaults, no prefix):
   - rst 2 cycles: all outputs 0.
   - inst=0x00F0, mode 0 -> next cycle out_valid=1, imm=0x00F0, prefixed=0.
   - inst=0x00F0, mode 2 -> imm=0xFFF0.
   - inst=0x0410, mode 1 -> imm=0xFC10.
   - inst=0x001A, mode 4 -> imm=0xFFFA.
2. Prefix concatenation:
   - inst=0xF001 -> out_valid=0, state HELD.
   - Next inst=0x000A, mode 4 -> imm=0x001A, prefixed=1.
   - inst=0xF400 then inst=0x0003, mode 3 -> imm=0x8003 (16-bit concat).
   - inst=0xF7FF then inst=0x00AB, mode 0 -> imm=0xFFAB (truncated from 19 bits).
3. Double prefix:
   - inst=0xF001 then inst=0xF002 -> prefix_err=1 for one cycle.
   - Following inst=0x0005, mode 4 -> imm=0x0025, prefix_err=0.
4. Stall:
   - Assert stall for 3 cycles with a valid output pending -> out_valid, imm, prefixed unchanged; the input instruction is not consumed.
   - A prefix held across the stall is still applied afterwards.
5. Flush:
   - inst=0xF001, then flush=1 together with stall=1 -> out_valid=0 and state IDLE.
   - Next inst=0x000A, mode 4 -> imm=0xFFFA, prefixed=0.
6. Reset mid-operation and bubbles:
   - Prefix held, rst=1 -> next non-prefix instruction extends as in IDLE.
   - in_valid=0 for 2 cycles after a prefix, then inst=0x000A, mode 4 -> still prefixed (imm=0x001A with prefix 0x001).
   - mode=6 -> imm=0, out_valid=1.
